// File: rtl/wheel_sample_ctrl.sv
// rtl/wheel_sample_ctrl.sv - two-wheel speed window scheduler and delta sampler
// Optional delta clamping is enabled by defining WHEEL_SAT_EN.

module wheel_sample_ctrl #(
  parameter int unsigned WINDOW_DEFAULT = 100000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DELTA_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [CNT_W-1:0]   pos_l,
  input  logic [CNT_W-1:0]   pos_r,
  input  logic               win_wr,
  input  logic [31:0]        win_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DELTA_W-1:0] out_dl,
  output logic [DELTA_W-1:0] out_dr,
  output logic [7:0]         out_seq,
  output logic               out_sat,
  output logic               overrun,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [31:0] WIN_RESET = 32'(WINDOW_DEFAULT);

  state_t             state_q, state_d;
  logic [31:0]        window_q, window_d;
  logic [31:0]        timer_q, timer_d;
  logic [CNT_W-1:0]   prev_l_q, prev_l_d;
  logic [CNT_W-1:0]   prev_r_q, prev_r_d;
  logic [7:0]         seq_q, seq_d;
  logic               out_valid_q, out_valid_d;
  logic [DELTA_W-1:0] out_dl_q, out_dl_d;
  logic [DELTA_W-1:0] out_dr_q, out_dr_d;
  logic [7:0]         out_seq_q, out_seq_d;
  logic               out_sat_q, out_sat_d;
  logic               overrun_q, overrun_d;

  logic               tick;
  logic               load;
  logic [CNT_W-1:0]   diff_l, diff_r;
  logic [DELTA_W-1:0] dl_fit, dr_fit;
  logic               sat_l, sat_r;

  // A window write or a disable suppresses the tick so the partial window yields nothing.
  assign tick   = (state_q == RUN) && enable && !win_wr && (timer_q == window_q - 32'd1);
  assign load   = tick && (!out_valid_q || out_ready);

  // Modular subtraction gives the correct signed delta across counter wrap.
  assign diff_l = pos_l - prev_l_q;
  assign diff_r = pos_r - prev_r_q;

`ifdef WHEEL_SAT_EN
  // Returns {clamped, value}; in range when the bits above the sign all match it.
  function automatic logic [DELTA_W:0] clamp_delta(input logic [CNT_W-1:0] d);
    logic [CNT_W-DELTA_W:0] top;
    top = d[CNT_W-1:DELTA_W-1];
    if (top == '0 || top == '1) begin
      clamp_delta = {1'b0, d[DELTA_W-1:0]};
    end else if (d[CNT_W-1]) begin
      clamp_delta = {1'b1, 1'b1, {(DELTA_W-1){1'b0}}};
    end else begin
      clamp_delta = {1'b1, 1'b0, {(DELTA_W-1){1'b1}}};
    end
  endfunction

  assign {sat_l, dl_fit} = clamp_delta(diff_l);
  assign {sat_r, dr_fit} = clamp_delta(diff_r);
`else
  logic diff_unused;

  assign dl_fit      = diff_l[DELTA_W-1:0];
  assign dr_fit      = diff_r[DELTA_W-1:0];
  assign sat_l       = 1'b0;
  assign sat_r       = 1'b0;
  assign diff_unused = ^{diff_l[CNT_W-1:DELTA_W], diff_r[CNT_W-1:DELTA_W]};
`endif

  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    timer_d     = 32'd0;
    prev_l_d    = prev_l_q;
    prev_r_d    = prev_r_q;
    seq_d       = seq_q;
    out_valid_d = out_valid_q;
    out_dl_d    = out_dl_q;
    out_dr_d    = out_dr_q;
    out_seq_d   = out_seq_q;
    out_sat_d   = out_sat_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME:   state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (enable && win_wr) state_d = PRIME;
    if (!enable)          state_d = IDLE;

    if (win_wr) begin
      window_d = (win_data < 32'd2) ? 32'd2 : win_data;
    end

    if (state_q == RUN && state_d == RUN && !tick) begin
      timer_d = timer_q + 32'd1;
    end

    if (state_q == PRIME || tick) begin
      prev_l_d = pos_l;
      prev_r_d = pos_r;
    end

    if (tick) begin
      seq_d = seq_q + 8'd1;
    end

    // A fresh sample may replace one being accepted in the same cycle.
    if (load) begin
      out_valid_d = 1'b1;
      out_dl_d    = dl_fit;
      out_dr_d    = dr_fit;
      out_seq_d   = seq_q + 8'd1;
      out_sat_d   = sat_l | sat_r;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (tick && !load) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      window_q    <= WIN_RESET;
      timer_q     <= 32'd0;
      prev_l_q    <= '0;
      prev_r_q    <= '0;
      seq_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_dl_q    <= '0;
      out_dr_q    <= '0;
      out_seq_q   <= 8'd0;
      out_sat_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      timer_q     <= timer_d;
      prev_l_q    <= prev_l_d;
      prev_r_q    <= prev_r_d;
      seq_q       <= seq_d;
      out_valid_q <= out_valid_d;
      out_dl_q    <= out_dl_d;
      out_dr_q    <= out_dr_d;
      out_seq_q   <= out_seq_d;
      out_sat_q   <= out_sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_dl    = out_dl_q;
  assign out_dr    = out_dr_q;
  assign out_seq   = out_seq_q;
  assign out_sat   = out_sat_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_wheel_sample_ctrl.sv
// tb/tb_wheel_sample_ctrl.sv - randomized scoreboard bench for wheel_sample_ctrl
// Reference model reasons in window start/tick cycle numbers, not in controller states.

module tb_wheel_sample_ctrl;

  localparam int unsigned WIN0    = 10;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned DELTA_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               enable = 1'b0;
  logic [CNT_W-1:0]   pos_l = '0;
  logic [CNT_W-1:0]   pos_r = '0;
  logic               win_wr = 1'b0;
  logic [31:0]        win_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [DELTA_W-1:0] out_dl;
  logic [DELTA_W-1:0] out_dr;
  logic [7:0]         out_seq;
  logic               out_sat;
  logic               overrun;
  logic               busy;

  wheel_sample_ctrl #(
    .WINDOW_DEFAULT(WIN0),
    .CNT_W(CNT_W),
    .DELTA_W(DELTA_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pos_l(pos_l), .pos_r(pos_r),
    .win_wr(win_wr), .win_data(win_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_dl(out_dl), .out_dr(out_dr), .out_seq(out_seq), .out_sat(out_sat),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DELTA_W-1:0] dl;
    logic [DELTA_W-1:0] dr;
    logic [7:0]         seq;
    logic               sat;
  } samp_t;

  samp_t sbq[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;
  logic [31:0] pl_v = '0;
  logic [31:0] pr_v = '0;

  int unsigned m_window;
  bit          m_active, m_pend, m_ovr;
  int          m_prime_at, m_tick_at, m_seq;
  logic [31:0] m_base_l, m_base_r;
  bit          vis_pend, vis_ovr, vis_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ideal delta: signed difference, then either clamp to range or keep low bits.
  task automatic fit(input logic [31:0] d, output logic [DELTA_W-1:0] v, output logic s);
    longint sd;
    longint dmax;
    sd   = longint'($signed(d));
    dmax = (longint'(1) <<< (DELTA_W - 1)) - 1;
    v = d[DELTA_W-1:0];
    s = 1'b0;
`ifdef WHEEL_SAT_EN
    if (sd > dmax) begin
      v = DELTA_W'(dmax);
      s = 1'b1;
    end else if (sd < -dmax - 1) begin
      v = DELTA_W'(-dmax - 1);
      s = 1'b1;
    end
`endif
  endtask

  task automatic model_reset();
    m_window = WIN0;
    m_active = 1'b0;
    m_pend   = 1'b0;
    m_ovr    = 1'b0;
    m_seq    = 0;
    m_prime_at = -1;
    m_tick_at  = -1;
    sbq.delete();
  endtask

  task automatic model_step(input bit r, input bit e, input bit w, input logic [31:0] wd,
                            input bit rd, input logic [31:0] pl, input logic [31:0] pr);
    samp_t s;
    logic  sl, sr;
    bit    tick;
    vis_pend = m_pend;
    vis_ovr  = m_ovr;
    vis_busy = m_active;
    if (!r) begin
      model_reset();
      vis_pend = 1'b0;
      vis_ovr  = 1'b0;
      vis_busy = 1'b0;
      return;
    end
    tick = 1'b0;
    if (w) m_window = (wd < 2) ? 2 : wd;
    if (!e) begin
      m_active = 1'b0;
    end else if (w || !m_active) begin
      m_active   = 1'b1;
      m_prime_at = cyc + 1;
      m_tick_at  = cyc + 1 + int'(m_window);
    end else begin
      if (cyc == m_prime_at) begin
        m_base_l = pl;
        m_base_r = pr;
      end
      if (cyc == m_tick_at) tick = 1'b1;
    end
    if (tick) begin
      fit(pl - m_base_l, s.dl, sl);
      fit(pr - m_base_r, s.dr, sr);
      s.sat = sl | sr;
      m_base_l  = pl;
      m_base_r  = pr;
      m_tick_at = cyc + int'(m_window);
      m_seq     = (m_seq + 1) % 256;
      s.seq     = 8'(m_seq);
      if (!m_pend || rd) begin
        sbq.push_back(s);
        m_pend = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_pend && rd) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit w, input logic [31:0] wd, input bit rd);
    @(posedge clk);
    #1;
    rst       = r;
    enable    = e;
    win_wr    = w;
    win_data  = wd;
    out_ready = rd;
    pos_l     = pl_v;
    pos_r     = pr_v;
    model_step(r, e, w, wd, rd, pl_v, pr_v);
    cyc++;
    mon_on = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, vis_pend});
      chk("overrun", {31'd0, overrun}, {31'd0, vis_ovr});
      chk("busy", {31'd0, busy}, {31'd0, vis_busy});
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("sample_expected", 32'd0, 32'd1);
        end else begin
          chk("out_dl", 32'(out_dl), 32'(sbq[0].dl));
          chk("out_dr", 32'(out_dr), 32'(sbq[0].dr));
          chk("out_seq", 32'(out_seq), 32'(sbq[0].seq));
          chk("out_sat", {31'd0, out_sat}, {31'd0, sbq[0].sat});
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    int first;
    model_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_dl", 32'(out_dl), 32'd0);
    chk("rst_out_dr", 32'(out_dr), 32'd0);
    chk("rst_out_seq", 32'(out_seq), 32'd0);
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

    // Ramp left across the 32-bit wrap, right held; first sample 12 cycles after enable.
    pl_v = 32'hFFFF_FFF8;
    pr_v = 32'h0000_1234;
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      pl_v = pl_v + 32'd1;
      drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      if (out_valid && first == 0) first = k;
    end
    chk("first_valid_latency", 32'(first), 32'd12);
    for (int k = 0; k < 40; k++) begin
      pl_v = pl_v + 32'd1;
      drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    end

    // Right wheel moves 4000/cycle: +40000 per window exceeds the delta range.
    for (int k = 0; k < 30; k++) begin
      pr_v = pr_v + 32'd4000;
      drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    end

    // Window write below the minimum mid-window, then a stalled consumer.
    drive(1'b1, 1'b1, 1'b1, 32'd1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      pl_v = pl_v + 32'd3;
      drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    end
    drive(1'b1, 1'b1, 1'b1, 32'd10, 1'b1);
    for (int k = 0; k < 25; k++) begin
      pl_v = pl_v - 32'd2;
      drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    end
    for (int k = 0; k < 12; k++) drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);

    for (int seg = 0; seg < 40; seg++) begin
      int unsigned mode_p;
      int unsigned mode_r;
      mode_p = $urandom_range(0, 2);
      mode_r = $urandom_range(0, 2);
      if (seg == 20) begin
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      end
      for (int k = 0; k < 100; k++) begin
        int          sl;
        int          sr;
        bit          e;
        bit          w;
        bit          rd;
        logic [31:0] wd;
        case (mode_p)
          0: begin
            sl = int'($urandom_range(0, 6)) - 3;
            sr = int'($urandom_range(0, 6)) - 3;
          end
          1: begin
            sl = int'($urandom_range(0, 800)) - 400;
            sr = int'($urandom_range(0, 800));
          end
          default: begin
            sl = int'($urandom_range(0, 16000)) - 8000;
            sr = int'($urandom_range(0, 9000));
          end
        endcase
        pl_v = pl_v + 32'(sl);
        pr_v = pr_v + 32'(sr);
        case (mode_r)
          0:       rd = 1'b1;
          1:       rd = ($urandom_range(0, 1) == 1);
          default: rd = ($urandom_range(0, 7) == 0);
        endcase
        e  = ($urandom_range(0, 149) != 0);
        w  = ($urandom_range(0, 59) == 0);
        wd = $urandom_range(0, 14);
        drive(1'b1, e, w, wd, rd);
      end
    end

    for (int k = 0; k < 30; k++) drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    #6;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
